// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_unit_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Depth-parameterised prefetch queue with synchronous flush; head reads as zero when empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [AW:0]  count
);
    localparam int CW = AW + 1;

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction prefetcher with redirect flush and in-order response tracking.
// Define FETCH_PERF_EN to add saturating fetch_count/flush_count performance outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pcout
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        flush_count
`endif
);
    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     occupancy;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     out_next;
    logic [CW-1:0]     occ_next;
    logic [CW-1:0]     credits_next;
    logic              accept;
    logic              resp;
    logic              resp_drop;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Outstanding counts every in-flight response, dropped or not, so credits never over-commit the queue.
    assign credits   = DEPTH_C - occupancy - outstanding;
    assign imem_req  = (state == FETCH) && (credits != '0);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_gnt;
    assign resp      = imem_rvalid && (outstanding != '0);
    assign resp_drop = resp && (drop != '0);
    assign push      = resp && !resp_drop && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;
    assign push_data = '{instr: imem_rdata, pc: resp_pc};

    assign out_next     = outstanding + CW'(accept) - CW'(resp);
    assign occ_next     = redirect ? '0 : (occupancy + CW'(push) - CW'(pop));
    assign credits_next = DEPTH_C - occ_next - out_next;

    // Surviving requests are consecutive from the last redirect, so one counter names each response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop     <= out_next;
                state    <= FETCH;
            end else begin
                if (accept) fetch_pc <= fetch_pc + ADDR_W'(1);
                if (push) resp_pc <= resp_pc + ADDR_W'(1);
                if (resp_drop) drop <= drop - CW'(1);
                case (state)
                    IDLE:    state <= FETCH;
                    FETCH:   if (credits_next == '0) state <= STALL;
                    STALL:   if (credits_next != '0) state <= FETCH;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (instr_valid),
        .count     (occupancy)
    );

    assign instruction = head.instr;
    assign pcout       = head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (accept && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
            if (redirect && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, a monitor checks each delivered instruction.
module tb_fetch_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_gnt;
    logic       imem_rvalid;
    logic [7:0] imem_rdata;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instruction;
    logic [7:0] pcout;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;
    int gntBudget = 0;
    int latency = 1;
    int acceptCount = 0;
    int cyc = 0;
    logic [7:0]  pendAddr [$];
    int          pendDue [$];
    logic [15:0] expQ [$];

    fetch_unit #(.RESET_PC(8'h00), .FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .pcout       (pcout)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] memData(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pc);
        expQ.push_back({pc, memData(pc)});
    endtask

    task automatic waitDrain(input int maxCycles, input string name);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic waitAccepts(input int target, input int maxCycles, input string name);
        int n = 0;
        while (acceptCount < target && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, acceptCount, target);
    endtask

    // Memory model: grants while budget remains, answers in order after a fixed latency.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 8'h00;
        forever begin
            @(negedge clock);
            cyc++;
            #1;
            if (pendAddr.size() != 0 && pendDue[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memData(pendAddr.pop_front());
                pendDue.delete(0);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 8'h00;
            end
            imem_gnt = (gntBudget > 0);
            #1;
            if (imem_req && imem_gnt && !reset) begin
                pendAddr.push_back(imem_addr);
                pendDue.push_back(cyc + latency);
                acceptCount++;
                gntBudget--;
            end
        end
    end

    // Monitor: every pop the DUT performs must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (instr_valid && instr_ready && !redirect && !reset) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_instr: got pc %0h instr %0h, expected none", pcout, instruction);
                end else begin
                    logic [15:0] e;
                    e = expQ.pop_front();
                    checkOutput("pcout", pcout, e[15:8]);
                    checkOutput("instruction", instruction, e[7:0]);
                end
            end
        end
    end

    initial begin
        int base;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(negedge clock);
        checkOutput("reset_req", imem_req, 0);
        checkOutput("reset_addr", imem_addr, 8'h00);
        checkOutput("reset_valid", instr_valid, 0);
        checkOutput("reset_instr", instruction, 8'h00);
        checkOutput("reset_pcout", pcout, 8'h00);

        $display("[TB] in-order fetch 00..03");
        reset       = 1'b0;
        instr_ready = 1'b1;
        gntBudget   = 4;
        for (int i = 0; i < 4; i++) applyStimulus(8'(i));
        waitDrain(40, "t2_drain");
        checkOutput("t2_accepts", acceptCount, 4);

        $display("[TB] decoder stalled, queue fills");
        base        = acceptCount;
        instr_ready = 1'b0;
        gntBudget   = 10;
        for (int i = 4; i < 8; i++) applyStimulus(8'(i));
        repeat (10) @(negedge clock);
        checkOutput("t3_accepts", acceptCount - base, 4);
        checkOutput("t3_stall_req", imem_req, 0);
        gntBudget   = 0;
        instr_ready = 1'b1;
        waitDrain(20, "t3_drain");

        $display("[TB] redirect with two responses in flight");
        latency   = 3;
        base      = acceptCount;
        gntBudget = 2;
        waitAccepts(base + 2, 20, "t4_inflight");
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clock);
        redirect = 1'b0;
        checkOutput("t4_valid_low", instr_valid, 0);
        checkOutput("t4_req", imem_req, 1);
        checkOutput("t4_addr", imem_addr, 8'h40);
        applyStimulus(8'h40);
        applyStimulus(8'h41);
        gntBudget = 2;
        waitDrain(30, "t4_drain");
        checkOutput("t4_accepts", acceptCount - base, 4);

        $display("[TB] address wrap FE..01");
        latency     = 1;
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        @(negedge clock);
        redirect = 1'b0;
        applyStimulus(8'hFE);
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        gntBudget = 4;
        waitDrain(30, "t5_drain");

        $display("[TB] redirect with pop and rvalid in the same cycle");
        base        = acceptCount;
        instr_ready = 1'b0;
        gntBudget   = 3;
        waitAccepts(base + 2, 20, "t6_inflight");
        checkOutput("t6_valid_before", instr_valid, 1);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h90;
        @(negedge clock);
        redirect = 1'b0;
        checkOutput("t6_flushed", instr_valid, 0);
        checkOutput("t6_addr", imem_addr, 8'h90);
        applyStimulus(8'h90);
        applyStimulus(8'h91);
        gntBudget = 2;
        waitDrain(20, "t6_drain");

        $display("[TB] reset with responses in flight");
        latency   = 3;
        base      = acceptCount;
        gntBudget = 2;
        waitAccepts(base + 2, 20, "t7_inflight");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t7_reset_addr", imem_addr, 8'h00);
        checkOutput("t7_reset_valid", instr_valid, 0);
        repeat (5) @(negedge clock);
        checkOutput("t7_stale_ignored", instr_valid, 0);

        $display("[TB] five fetches then back-to-back redirects");
        latency   = 1;
        gntBudget = 5;
        for (int i = 0; i < 5; i++) applyStimulus(8'(i));
        waitDrain(30, "t8_drain");
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        @(negedge clock);
        redirect_pc = 8'h20;
        @(negedge clock);
        redirect = 1'b0;
        checkOutput("t8_last_redirect", imem_addr, 8'h20);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_count", fetch_count, 5);
        checkOutput("perf_flush_count", flush_count, 2);
`endif
        applyStimulus(8'h20);
        gntBudget = 1;
        waitDrain(20, "t8_final");
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
